// File: rtl/counter_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : counter_scheduler
//  Purpose  : Round-robin arbiter that shares one external counter timer
//             among NUM_REQ requesters. The winner's duration is latched at
//             grant, the timer enable is driven for the owner, and a
//             one-cycle done (or aborted) pulse is returned when the timer
//             reaches the duration (or the owner withdraws its request).
//  Ports    : clock_i            - clock, rising edge
//             reset_i            - asynchronous reset, active-high
//             req_i              - level request per requester
//             duration_i         - per-requester target count, slice i*CW
//             grant_o            - one-hot owner of the timer, 0 when idle
//             done_o             - one-cycle completion pulse to owner
//             aborted_o          - one-cycle pulse when owner dropped req
//             busy_o             - high in every state except IDLE
//             counter_enable_o   - to counter.enable_i
//             counter_val_i      - from counter.counter_val_o
//             counter_finished_i - from counter.finished_o
//  Revision : 1.0 - initial release
// ============================================================================
module counter_scheduler #(
    parameter int NUM_REQ           = 4,
    parameter int MAX_COUNTER_VALUE = 2000,
    localparam int CW = $clog2(MAX_COUNTER_VALUE + 1),
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic [NUM_REQ-1:0]    req_i,
    input  logic [NUM_REQ*CW-1:0] duration_i,
    output logic [NUM_REQ-1:0]    grant_o,
    output logic [NUM_REQ-1:0]    done_o,
    output logic [NUM_REQ-1:0]    aborted_o,
    output logic                  busy_o,
    output logic                  counter_enable_o,
    input  logic [CW-1:0]         counter_val_i,
    input  logic                  counter_finished_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        last_q, last_d;      // last winner == current owner while busy
    logic [CW-1:0]        dur_q, dur_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [NUM_REQ-1:0]   aborted_q, aborted_d;
    logic                 enable_q, enable_d;
    logic                 busy_q;

    logic [IW-1:0]        win_idx;
    logic [CW-1:0]        win_dur;
    logic                 complete;

    // Search starts one past the previous winner and wraps, so every
    // requester is reached within NUM_REQ arbitrations.
    function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [IW-1:0]      last);
        logic [IW-1:0] pick;
        logic          found;
        int            cand;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last) + k) % NUM_REQ;
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = IW'(cand);
            end
        end
        return pick;
    endfunction

    assign win_idx  = rr_pick(req_i, last_q);
    assign win_dur  = duration_i[win_idx*CW +: CW];

    // The finished flag covers durations beyond the counter's range, which
    // the value comparison alone could never reach.
    assign complete = (counter_val_i >= dur_q) || counter_finished_i;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        dur_d     = dur_q;
        grant_d   = grant_q;
        done_d    = '0;
        aborted_d = '0;
        enable_d  = enable_q;

        case (state_q)
            S_IDLE: begin
                if (|req_i) begin
                    state_d  = S_ARM;
                    last_d   = win_idx;
                    dur_d    = win_dur;
                    grant_d  = NUM_REQ'(1) << win_idx;
                    enable_d = 1'b1;
                end
            end
            // The counter clears on the enable rising edge during this
            // cycle, so its value is stale and must not be evaluated yet.
            S_ARM: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (complete) begin
                    state_d  = S_DONE;
                    done_d   = grant_q;
                    grant_d  = '0;
                    enable_d = 1'b0;
                end else if (!req_i[last_q]) begin
                    state_d   = S_DONE;
                    aborted_d = grant_q;
                    grant_d   = '0;
                    enable_d  = 1'b0;
                end
            end
            // Together with IDLE this keeps enable low for at least two
            // cycles so the counter sees a clean rising edge on re-grant.
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                grant_d  = '0;
                enable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            last_q    <= IW'(NUM_REQ - 1);
            dur_q     <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            aborted_q <= '0;
            enable_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            dur_q     <= dur_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            enable_q  <= enable_d;
            busy_q    <= (state_d != S_IDLE);
        end
    end

    assign grant_o          = grant_q;
    assign done_o           = done_q;
    assign aborted_o        = aborted_q;
    assign busy_o           = busy_q;
    assign counter_enable_o = enable_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_counter_scheduler
//  Purpose  : Self-checking bench for counter_scheduler. Includes a
//             behavioural model of the shared counter, a transaction-level
//             expectation model (round-robin order and latency arithmetic)
//             feeding a scoreboard queue, and a monitor that pops and checks
//             on every grant and done/aborted pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_counter_scheduler;

    localparam int NREQ = 4;
    localparam int MAXV = 2000;
    localparam int CW   = $clog2(MAXV + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*CW-1:0] dur_bus = '0;
    logic [NREQ-1:0]   grant_o, done_o, aborted_o;
    logic              busy_o, en;
    logic [CW-1:0]     cnt_val;
    logic              cnt_prev_en;
    logic              cnt_fin;

    int cyc = 0;
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int idx;
        bit ab;
        int lat;
        bit gap;
    } exp_t;

    exp_t sb[$];
    int   model_last = NREQ - 1;
    int   ep_dur[NREQ];
    int   ep_drop[NREQ];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    counter_scheduler #(
        .NUM_REQ           (NREQ),
        .MAX_COUNTER_VALUE (MAXV)
    ) dut (
        .clock_i            (clk),
        .reset_i            (rst),
        .req_i              (req),
        .duration_i         (dur_bus),
        .grant_o            (grant_o),
        .done_o             (done_o),
        .aborted_o          (aborted_o),
        .busy_o             (busy_o),
        .counter_enable_o   (en),
        .counter_val_i      (cnt_val),
        .counter_finished_i (cnt_fin)
    );

    // External counter: clears on enable rising edge, then counts up and
    // saturates at MAXV; finished flags saturation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_val     <= '0;
            cnt_prev_en <= 1'b0;
        end else begin
            cnt_prev_en <= en;
            if (en && !cnt_prev_en)
                cnt_val <= '0;
            else if (en && cnt_val < CW'(MAXV))
                cnt_val <= cnt_val + 1'b1;
        end
    end
    assign cnt_fin = (cnt_val == CW'(MAXV));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Timing from grant edge: completion lands at min(dur,MAX)+2 edges.
    // A drop t cycles after grant is seen at edge max(t+1,2); it aborts only
    // if that edge comes strictly before completion.
    function automatic int exp_lat(input int d, input int t, output bit ab);
        int c;
        int l;
        c  = ((d < MAXV) ? d : MAXV) + 2;
        ab = 1'b0;
        if (t >= 0) begin
            l = (t + 1 < 2) ? 2 : t + 1;
            if (l < c) begin
                ab = 1'b1;
                return l;
            end
        end
        return c;
    endfunction

    // Monitor: pops expectations as the DUT presents grants and pulses.
    logic [NREQ-1:0] mon_prev_grant = '0;
    int mon_gcyc     = 0;
    int mon_en_cnt   = 0;
    int mon_last_end = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            mon_prev_grant = '0;
            mon_en_cnt     = 0;
        end else begin
            check("onehot_outputs", 64'($countones({grant_o, done_o, aborted_o}) <= 1), 1);
            check("enable_vs_grant", en, |grant_o);
            check("busy_vs_activity", busy_o, |(grant_o | done_o | aborted_o));
            if (grant_o != '0 && mon_prev_grant == '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_grant", grant_o, 0);
                end else begin
                    check("grant_owner", grant_o, 64'(1) << sb[0].idx);
                    if (sb[0].gap)
                        check("grant_turnaround", cyc - mon_last_end, 2);
                end
                mon_gcyc   = cyc;
                mon_en_cnt = 0;
            end
            if (en) mon_en_cnt++;
            if ((done_o | aborted_o) != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", done_o | aborted_o, 0);
                end else begin
                    e = sb.pop_front();
                    check("pulse_owner", done_o | aborted_o, 64'(1) << e.idx);
                    check("pulse_is_abort", |aborted_o, e.ab);
                    check("latency", cyc - mon_gcyc, e.lat);
                    check("enable_cycles", mon_en_cnt, e.lat);
                end
                mon_last_end = cyc;
            end
            mon_prev_grant = grant_o;
        end
    end

    task automatic clear_ep();
        for (int i = 0; i < NREQ; i++) begin
            ep_dur[i]  = 0;
            ep_drop[i] = -1;
        end
    endtask

    // Raise all requests in `set` together while idle; each holds its
    // request until served (or its scheduled drop).
    task automatic run_episode(input logic [NREQ-1:0] set);
        exp_t            e;
        bit              ab;
        bit              first;
        int              lat;
        int              pos;
        int              budget;
        int              new_last;
        int              gcyc[NREQ];
        bit              gseen[NREQ];
        logic [NREQ-1:0] served;

        first    = 1'b1;
        new_last = model_last;
        for (int k = 1; k <= NREQ; k++) begin
            pos = (model_last + k) % NREQ;
            if (set[pos]) begin
                lat   = exp_lat(ep_dur[pos], ep_drop[pos], ab);
                e     = '{idx: pos, ab: ab, lat: lat, gap: !first};
                sb.push_back(e);
                first    = 1'b0;
                new_last = pos;
            end
        end
        model_last = new_last;

        for (int i = 0; i < NREQ; i++) begin
            dur_bus[i*CW +: CW] = CW'(ep_dur[i]);
            gseen[i] = 1'b0;
            gcyc[i]  = 0;
        end
        req    = set;
        served = '0;
        budget = 0;
        while (served != set && budget < 5000) begin
            @(negedge clk);
            budget++;
            for (int i = 0; i < NREQ; i++) begin
                if (set[i] && !served[i]) begin
                    if (grant_o[i] && !gseen[i]) begin
                        gseen[i] = 1'b1;
                        gcyc[i]  = cyc;
                        // Duration is latched at grant; scramble the input.
                        dur_bus[i*CW +: CW] = CW'($urandom_range(0, 2047));
                    end
                    if (gseen[i] && ep_drop[i] >= 0 && cyc - gcyc[i] == ep_drop[i])
                        req[i] = 1'b0;
                    if (done_o[i] || aborted_o[i]) begin
                        req[i]    = 1'b0;
                        served[i] = 1'b1;
                    end
                end
            end
        end
        check("episode_served", served, set);
        req = '0;
        @(negedge clk);
        @(negedge clk);
        check("idle_after_episode", {busy_o, en, grant_o}, 0);
    endtask

    initial begin
        int w;
        logic [NREQ-1:0] rset;

        // Reset held, no requests.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("rst_grant", grant_o, 0);
            check("rst_done", done_o, 0);
            check("rst_aborted", aborted_o, 0);
            check("rst_busy", busy_o, 0);
            check("rst_enable", en, 0);
        end
        rst = 1'b0;
        @(negedge clk);

        // All four requesting with zero duration: order 0,1,2,3.
        clear_ep();
        run_episode(4'b1111);

        // Single requester, duration 5: done 7 edges after grant.
        clear_ep();
        ep_dur[0] = 5;
        run_episode(4'b0001);

        // Duration beyond the counter range (3000 does not fit in CW bits,
        // so the largest encodable value is used): finishes via saturation.
        clear_ep();
        ep_dur[1] = 2047;
        run_episode(4'b0010);

        // Drop at counter value 4 -> abort; drop exactly at 10 -> done wins.
        clear_ep();
        ep_dur[0]  = 10;
        ep_drop[0] = 5;
        run_episode(4'b0001);
        clear_ep();
        ep_dur[0]  = 10;
        ep_drop[0] = 11;
        run_episode(4'b0001);

        // Drop during ARM with nonzero duration -> abort at first RUN check.
        clear_ep();
        ep_dur[3]  = 4;
        ep_drop[3] = 0;
        run_episode(4'b1000);

        // Randomised episodes.
        for (int n = 0; n < 40; n++) begin
            clear_ep();
            rset = NREQ'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) begin
                ep_dur[i]  = $urandom_range(0, 12);
                ep_drop[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : -1;
            end
            run_episode(rset);
        end

        // Asynchronous reset in the middle of RUN.
        clear_ep();
        dur_bus[0 +: CW] = CW'(50);
        sb.push_back('{idx: 0, ab: 1'b0, lat: 52, gap: 1'b0});
        req = 4'b0001;
        w = 0;
        while (!grant_o[0] && w < 10) begin
            @(negedge clk);
            w++;
        end
        check("pre_reset_grant", grant_o, 4'b0001);
        repeat (8) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_grant", grant_o, 0);
        check("async_rst_enable", en, 0);
        check("async_rst_busy", busy_o, 0);
        sb.delete();
        model_last = NREQ - 1;
        req = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_ep();
        ep_dur[2] = 2;
        run_episode(4'b0100);

        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
